// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the VGA output path.
//
// Produces horizontal/vertical sync, the current pixel coordinates and a
// display-active flag from a pair of free-running raster counters. A
// one-clk frame_tick marks the start of vertical blanking so downstream
// game state can update once per frame while nothing is being drawn.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous, active-low reset
//   pix_en       out  pixel strobe; counters advance on edges where it is high
//   x[9:0]       out  horizontal position (hcount, 0..H_TOTAL-1)
//   y[8:0]       out  vertical position while visible, else 0
//   display_on   out  high inside the visible window
//   hsync        out  horizontal sync, SYNC_ACTIVE while asserted
//   vsync        out  vertical sync, SYNC_ACTIVE while asserted
//   line_tick    out  one-clk pulse at the start of every line
//   frame_tick   out  one-clk pulse at the start of vertical blanking
//   frame_count  out  frames completed, wraps 255 -> 0
module vga_timing #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned CLK_DIV     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [1:0] PS_LAST  = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [1:0] r_prescaler;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_line_tick;
    logic       r_frame_tick;
    logic [7:0] r_frame_count;

    logic w_pix_en;
    logic w_h_last;
    logic w_v_last;
    logic w_h_vis;
    logic w_v_vis;

    always_comb begin
        w_pix_en = (r_prescaler == PS_LAST);
        w_h_last = (r_hcount == H_LAST);
        w_v_last = (r_vcount == V_LAST);
        w_h_vis  = (r_hcount < H_VIS);
        w_v_vis  = (r_vcount < V_VIS);
    end

    // Ticks are cleared every clk and only set on the advancing edge, so they
    // stay one clk wide even when each counter state lasts CLK_DIV clks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prescaler   <= '0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_line_tick   <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
            if (w_pix_en) begin
                r_prescaler <= '0;
                if (w_h_last) begin
                    r_hcount    <= '0;
                    r_line_tick <= 1'b1;
                    if (w_v_last) begin
                        r_vcount <= '0;
                    end else begin
                        r_vcount <= r_vcount + 10'd1;
                    end
                    // Entering line V_VISIBLE: first line of vertical blanking.
                    if (r_vcount == V_VIS_M1) begin
                        r_frame_tick  <= 1'b1;
                        r_frame_count <= r_frame_count + 8'd1;
                    end
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end else begin
                r_prescaler <= r_prescaler + 2'd1;
            end
        end
    end

    always_comb begin
        pix_en      = w_pix_en;
        x           = r_hcount;
        y           = w_v_vis ? r_vcount[8:0] : '0;
        display_on  = w_h_vis && w_v_vis;
        hsync       = (r_hcount >= HS_START && r_hcount <= HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync       = (r_vcount >= VS_START && r_vcount <= VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        line_tick   = r_line_tick;
        frame_tick  = r_frame_tick;
        frame_count = r_frame_count;
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing.
// Two instances share clock and reset: a CLK_DIV=1 instance with active-low
// syncs and a CLK_DIV=2 instance with active-high syncs, both on a reduced
// 16x9 raster (8x4 visible) so hundreds of frames fit in a short run.
module tb_vga_timing;

    localparam int unsigned HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VV = 4, VF = 1, VS = 2, VB = 2;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] x;
        logic [8:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       lt;
        logic       ft;
        logic [7:0] fc;
    } obs_t;

    logic clk;
    logic rst_n;

    logic       pe1, de1, hs1, vs1, lt1, ft1;
    logic [9:0] x1;
    logic [8:0] y1;
    logic [7:0] fc1;
    logic       pe2, de2, hs2, vs2, lt2, ft2;
    logic [9:0] x2;
    logic [8:0] y2;
    logic [7:0] fc2;

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0), .CLK_DIV(1)
    ) u_div1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe1), .x(x1), .y(y1),
        .display_on(de1), .hsync(hs1), .vsync(vs1), .line_tick(lt1),
        .frame_tick(ft1), .frame_count(fc1)
    );

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b1), .CLK_DIV(2)
    ) u_div2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe2), .x(x2), .y(y2),
        .display_on(de2), .hsync(hs2), .vsync(vs2), .line_tick(lt2),
        .frame_tick(ft2), .frame_count(fc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ft1_seen = 0;
    int unsigned ft2_seen = 0;

    obs_t q1[$];
    obs_t q2[$];

    // Expected outputs n clk edges after the last reset edge, derived from
    // elapsed pixel count: p = n / d pixels have gone by since reset.
    function automatic obs_t model(input int unsigned n, input int unsigned d, input logic sa);
        obs_t m;
        int unsigned p, h, v, fc;
        logic adv;
        p = n / d;
        h = p % HT;
        v = (p / HT) % VT;
        adv = (n > 0) && (n % d == 0);
        m.pix_en = ((n % d) == d - 1);
        m.x  = 10'(h);
        m.y  = (v < VV) ? 9'(v) : 9'd0;
        m.de = (h < HV) && (v < VV);
        m.hs = (h >= HV + HF && h < HV + HF + HS) ? sa : ~sa;
        m.vs = (v >= VV + VF && v < VV + VF + VS) ? sa : ~sa;
        m.lt = adv && (h == 0);
        m.ft = m.lt && (v == VV);
        if (p >= VV * HT) fc = (p - VV * HT) / FRAME + 1;
        else fc = 0;
        m.fc = 8'(fc % 256);
        return m;
    endfunction

    // Reference model: tracks elapsed clks since reset, pushes expectations.
    initial begin
        int unsigned n;
        bit seen;
        n = 0;
        seen = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n = 0;
                seen = 1;
            end else begin
                n++;
            end
            if (seen) begin
                q1.push_back(model(n, 1, 1'b0));
                q2.push_back(model(n, 2, 1'b1));
            end
        end
    end

    // Monitor: compares whatever each DUT presents against the queue head.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {pe1, x1, y1, de1, hs1, vs1, lt1, ft1, fc1};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL div1_cycle got pe=%b x=%0d y=%0d de=%b hs=%b vs=%b lt=%b ft=%b fc=%0d expected pe=%b x=%0d y=%0d de=%b hs=%b vs=%b lt=%b ft=%b fc=%0d",
                             a.pix_en, a.x, a.y, a.de, a.hs, a.vs, a.lt, a.ft, a.fc,
                             e.pix_en, e.x, e.y, e.de, e.hs, e.vs, e.lt, e.ft, e.fc);
                end
                if (ft1 === 1'b1) ft1_seen++;
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                a = {pe2, x2, y2, de2, hs2, vs2, lt2, ft2, fc2};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL div2_cycle got pe=%b x=%0d y=%0d de=%b hs=%b vs=%b lt=%b ft=%b fc=%0d expected pe=%b x=%0d y=%0d de=%b hs=%b vs=%b lt=%b ft=%b fc=%0d",
                             a.pix_en, a.x, a.y, a.de, a.hs, a.vs, a.lt, a.ft, a.fc,
                             e.pix_en, e.x, e.y, e.de, e.hs, e.vs, e.lt, e.ft, e.fc);
                end
                if (ft2 === 1'b1) ft2_seen++;
            end
        end
    end

    task automatic check_val(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Stimulus: reset sequences only; the raster is free-running.
    initial begin
        int unsigned wrap_len;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset landing inside both syncs of the CLK_DIV=1 instance:
        // third frame, line VV+VF, pixel HV+HF+1.
        repeat (2 * FRAME + (VV + VF) * HT + HV + HF + 1) @(negedge clk);
        check_val("pre_reset_hsync_div1", int'(hs1), 0);
        check_val("pre_reset_vsync_div1", int'(vs1), 0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_val("mid_reset_x", int'(x1), 0);
        check_val("mid_reset_y", int'(y1), 0);
        check_val("mid_reset_hsync", int'(hs1), 1);
        check_val("mid_reset_vsync", int'(vs1), 1);
        check_val("mid_reset_frame_tick", int'(ft1), 0);
        rst_n = 1'b1;

        // Randomized reset pulses of 1..3 clks at arbitrary raster positions.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 3 * FRAME)) @(negedge clk);
            rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
        end

        // Long uninterrupted run: 256 frame ticks on the CLK_DIV=1 instance,
        // 128 on the CLK_DIV=2 instance.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        ft1_seen = 0;
        ft2_seen = 0;
        wrap_len = VV * HT + 255 * FRAME + 10;
        @(negedge clk);
        repeat (wrap_len - 1) @(negedge clk);
        #1;
        check_val("wrap_ticks_div1", ft1_seen, 256);
        check_val("wrap_fc_div1", int'(fc1), 0);
        check_val("wrap_ticks_div2", ft2_seen, 128);
        check_val("wrap_fc_div2", int'(fc2), 128);

        @(negedge clk);
        #1;
        check_val("queue1_drained", q1.size(), 0);
        check_val("queue2_drained", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
